// File: rtl/icp_capture_1024hz.sv
// Input-capture unit: free-running prescaled timebase, latched on a selected icp edge.
// Optional ICP_NOISE_CANCEL_EN adds a 4-sample level filter ahead of edge detection.
//
// state | meaning
// IDLE  | no capture held (icr_valid=0)
// FULL  | capture held, not yet acknowledged
// OVR   | capture held and a later edge was dropped
module icp_capture_1024hz #(
   parameter int unsigned PRESCALE_MAX = 48828,
   parameter int unsigned TCNT_W       = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              icp_i,
   input  logic              edge_sel_i,
   input  logic              icr_ack_i,
   output logic              tick_o,
   output logic [TCNT_W-1:0] tcnt_o,
   output logic [TCNT_W-1:0] icr_o,
   output logic              icr_valid_o,
   output logic              icr_ovr_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FULL = 2'd1,
      OVR  = 2'd2
   } state_t;

   localparam logic [15:0]       PS_MAX   = 16'(PRESCALE_MAX);
   localparam logic [TCNT_W-1:0] TCNT_ONE = {{(TCNT_W-1){1'b0}}, 1'b1};

`ifdef ICP_NOISE_CANCEL_EN
   localparam int unsigned      ARM_W   = 3;
   localparam logic [ARM_W-1:0] ARM_MAX = 3'd6;
`else
   localparam int unsigned      ARM_W   = 2;
   localparam logic [ARM_W-1:0] ARM_MAX = 2'd2;
`endif
   localparam logic [ARM_W-1:0] ARM_ONE = {{(ARM_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [15:0]       ps_q, ps_d;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
   logic [TCNT_W-1:0] icr_q, icr_d;
   logic [ARM_W-1:0]  arm_q, arm_d;
   logic              s1_q, s2_q;
   logic              hist_q, hist_d;
   logic              lvl, lvl_nxt;
   logic              armed, hit, load, tick;

   assign tick   = (ps_q == PS_MAX);
   assign ps_d   = tick ? 16'd0 : ps_q + 16'd1;
   assign tcnt_d = tick ? tcnt_q + TCNT_ONE : tcnt_q;
   assign armed  = (arm_q == ARM_MAX);
   assign arm_d  = armed ? arm_q : arm_q + ARM_ONE;

`ifdef ICP_NOISE_CANCEL_EN
   logic [2:0] sh_q;
   logic       filt_q, filt_d;

   // Window is s2 plus three older samples, so the filter settles on the edge the 4th equal sample arrives.
   always_comb begin
      filt_d = filt_q;
      if ((&{sh_q, s2_q}) || !(|{sh_q, s2_q})) filt_d = s2_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sh_q   <= 3'b000;
         filt_q <= 1'b0;
      end else begin
         sh_q   <= {sh_q[1:0], s2_q};
         filt_q <= filt_d;
      end
   end

   assign lvl     = filt_q;
   assign lvl_nxt = filt_d;
`else
   assign lvl     = s2_q;
   assign lvl_nxt = s1_q;
`endif

   // While arming, hist tracks the incoming level so the pin state at reset release is not seen as an edge.
   assign hist_d = armed ? lvl : lvl_nxt;
   assign hit    = armed && (edge_sel_i ? (lvl && !hist_q) : (!lvl && hist_q));
   assign load   = hit && ((state_q == IDLE) || icr_ack_i);

   always_comb begin
      state_d = state_q;
      icr_d   = icr_q;
      if (load) icr_d = tcnt_q;
      case (state_q)
         IDLE: if (hit) state_d = FULL;
         FULL,
         OVR: begin
            if (hit && icr_ack_i) state_d = FULL;
            else if (icr_ack_i)   state_d = IDLE;
            else if (hit)         state_d = OVR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ps_q    <= 16'd0;
         tcnt_q  <= '0;
         icr_q   <= '0;
         arm_q   <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         tcnt_q  <= tcnt_d;
         icr_q   <= icr_d;
         arm_q   <= arm_d;
         s1_q    <= icp_i;
         s2_q    <= s1_q;
         hist_q  <= hist_d;
      end
   end

   assign tick_o      = tick;
   assign tcnt_o      = tcnt_q;
   assign icr_o       = icr_q;
   assign icr_valid_o = (state_q != IDLE);
   assign icr_ovr_o   = (state_q == OVR);

endmodule

// File: tb/tb_icp_capture_1024hz.sv
// Self-checking bench for icp_capture_1024hz with a shortened prescaler (tick every 4 clocks).
module tb_icp_capture_1024hz;
   localparam int PSM = 3;
   localparam int TW  = 10;
`ifdef ICP_NOISE_CANCEL_EN
   localparam int FIRST_HIT = 7;
`else
   localparam int FIRST_HIT = 3;
`endif

   logic          clk = 1'b0;
   logic          rst, icp, edge_sel, icr_ack;
   logic          tick, icr_valid, icr_ovr;
   logic [TW-1:0] tcnt, icr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   always #5 clk = ~clk;

   icp_capture_1024hz #(.PRESCALE_MAX(PSM), .TCNT_W(TW)) dut (
      .clk_i(clk), .rst_i(rst), .icp_i(icp), .edge_sel_i(edge_sel), .icr_ack_i(icr_ack),
      .tick_o(tick), .tcnt_o(tcnt), .icr_o(icr), .icr_valid_o(icr_valid), .icr_ovr_o(icr_ovr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: k = clock edges since reset release; pin_h[j] = icp seen at edge j,
   // lvl_h[j] = level the edge detector sees after edge j.
   int            k;
   logic          pin_h [0:8191];
   logic          lvl_h [0:8191];
   logic          m_valid, m_ovr;
   logic [TW-1:0] m_icr;

   function automatic logic level_at(input int j);
`ifdef ICP_NOISE_CANCEL_EN
      if (j < 6) return 1'b0;
      if (pin_h[j-2] == pin_h[j-3] && pin_h[j-3] == pin_h[j-4] && pin_h[j-4] == pin_h[j-5])
         return pin_h[j-2];
      return lvl_h[j-1];
`else
      if (j < 2) return 1'b0;
      return pin_h[j-1];
`endif
   endfunction

   always @(posedge clk) begin : model
      logic hit;
      if (rst) begin
         k = 0; m_valid = 1'b0; m_ovr = 1'b0; m_icr = '0;
      end else begin
         hit = 1'b0;
         if (k >= FIRST_HIT)
            hit = edge_sel ? (lvl_h[k] && !lvl_h[k-1]) : (!lvl_h[k] && lvl_h[k-1]);
         if (hit) begin
            if (!m_valid || icr_ack) begin
               m_icr = TW'((k / (PSM + 1)) % 1024);
               m_valid = 1'b1; m_ovr = 1'b0;
            end else m_ovr = 1'b1;
         end else if (icr_ack) begin
            m_valid = 1'b0; m_ovr = 1'b0;
         end
         k++;
         pin_h[k] = icp;
         lvl_h[k] = level_at(k);
      end
   end

   always @(negedge clk) begin : compare
      if (rst) begin
         check("rst_tick", 32'(tick), 0);
         check("rst_tcnt", 32'(tcnt), 0);
         check("rst_icr", 32'(icr), 0);
         check("rst_valid", 32'(icr_valid), 0);
         check("rst_ovr", 32'(icr_ovr), 0);
      end else begin
         check("tick", 32'(tick), 32'((k % (PSM + 1)) == PSM));
         check("tcnt", 32'(tcnt), 32'((k / (PSM + 1)) % 1024));
         check("icr", 32'(icr), 32'(m_icr));
         check("icr_valid", 32'(icr_valid), 32'(m_valid));
         check("icr_ovr", 32'(icr_ovr), 32'(m_ovr));
      end
   end

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_tcnt", 32'(tcnt), 0);
      check("async_icr", 32'(icr), 0);
      check("async_valid", 32'(icr_valid), 0);
      check("async_ovr", 32'(icr_ovr), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      int ticks, wraps, prev;
      rst = 1'b1; icp = 1'b1; edge_sel = 1'b1; icr_ack = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0; cyc = 0;

      // Timebase over a full wrap, pin held high through reset release.
      ticks = 0; wraps = 0; prev = 0;
      for (int i = 1; i <= 4100; i++) begin
         step();
         if (tick) ticks++;
         if (prev == 1023 && tcnt == 0) wraps++;
         prev = int'(tcnt);
      end
      check("tick_count", 32'(ticks), 1025);
      check("wrap_count", 32'(wraps), 1);
      check("tcnt_after", 32'(tcnt), 1);
      check("no_false_cap", 32'(icr_valid), 0);

`ifdef ICP_NOISE_CANCEL_EN
      do_reset();
      icp = 1'b0; edge_sel = 1'b1;
      run_to(20); icp = 1'b1;
      run_to(23); icp = 1'b0;
      run_to(40); check("glitch_rej", 32'(icr_valid), 0);
      icp = 1'b1;
      run_to(44); icp = 1'b0;
      run_to(46); check("nc_lat_early", 32'(icr_valid), 0);
      run_to(47); check("nc_valid", 32'(icr_valid), 1);
      check("nc_icr", 32'(icr), 11);
`else
      // Hit cycle coincides with a tick: the pre-increment count is captured.
      do_reset();
      icp = 1'b0; edge_sel = 1'b1;
      run_to(21); icp = 1'b1;
      run_to(23); check("bnd_early", 32'(icr_valid), 0);
      run_to(24); check("bnd_icr", 32'(icr), 5);
      check("bnd_valid", 32'(icr_valid), 1);
      check("bnd_tcnt", 32'(tcnt), 6);

      // Reset while a capture is held.
      do_reset();
      icp = 1'b0;
      run_to(19); icp = 1'b1;
      run_to(21); check("rise_early", 32'(icr_valid), 0);
      run_to(22); check("rise_icr", 32'(icr), 5);
      check("rise_valid", 32'(icr_valid), 1);
      icr_ack = 1'b1;
      step(); icr_ack = 1'b0;
      check("ack_clr", 32'(icr_valid), 0);

      // Falling select.
      do_reset();
      icp = 1'b0; edge_sel = 1'b0;
      run_to(40); icp = 1'b1;
      run_to(45); check("fall_no_rise", 32'(icr_valid), 0);
      run_to(50); icp = 1'b0;
      run_to(52); check("fall_early", 32'(icr_valid), 0);
      run_to(53); check("fall_icr", 32'(icr), 13);
      check("fall_valid", 32'(icr_valid), 1);
      icr_ack = 1'b1;
      step(); icr_ack = 1'b0;

      // Overrun, then overrun cleared by an ack coinciding with a new hit.
      do_reset();
      icp = 1'b0; edge_sel = 1'b1;
      run_to(20); icp = 1'b1;
      run_to(26); icp = 1'b0;
      run_to(30); icp = 1'b1;
      run_to(33); check("ovr_icr", 32'(icr), 5);
      check("ovr_flag", 32'(icr_ovr), 1);
      check("ovr_valid", 32'(icr_valid), 1);
      run_to(35); icr_ack = 1'b1;
      run_to(36); icr_ack = 1'b0;
      check("ovr_ack_v", 32'(icr_valid), 0);
      check("ovr_ack_o", 32'(icr_ovr), 0);
      run_to(40); icp = 1'b0;
      run_to(44); icp = 1'b1;
      run_to(48); icp = 1'b0;
      run_to(52); icp = 1'b1;
      run_to(55); check("ovr2_icr", 32'(icr), 11);
      check("ovr2_flag", 32'(icr_ovr), 1);
      run_to(56); icp = 1'b0;
      run_to(60); icp = 1'b1;
      run_to(62); icr_ack = 1'b1;
      run_to(63); icr_ack = 1'b0;
      check("hitack_icr", 32'(icr), 15);
      check("hitack_valid", 32'(icr_valid), 1);
      check("hitack_ovr", 32'(icr_ovr), 0);
      run_to(66); icr_ack = 1'b1;
      run_to(67); icr_ack = 1'b0;
      check("ack_idle1", 32'(icr_valid), 0);
      run_to(68); icr_ack = 1'b1;
      run_to(69); icr_ack = 1'b0;
      check("ack_idle2", 32'(icr_valid), 0);
      check("ack_idle_icr", 32'(icr), 15);
`endif
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
